// File: rtl/mc_sos_iir.sv
// mc_sos_iir: time-multiplexed multi-channel cascade of Direct Form I biquads on one shared MAC
module mc_sos_iir #(
    parameter int CHANNELS = 4,
    parameter int SECTIONS = 8,
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int OB = 0,
    parameter logic [SECTIONS*5-1:0][CW-1:0] COEFFICIENTS = '0,
    parameter RAMSTYLE = "logic"
) (
    input  logic                                                clk_i,
    input  logic                                                srst_i,
    input  logic                                                start_i,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  channel_i,
    input  logic signed [DW-1:0]                                data_i,
    output logic signed [DW-1:0]                                data_o,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  channel_o,
    output logic                                                data_valid_o,
    output logic                                                busy_o,
    output logic                                                drop_o
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int NE = CHANNELS * SECTIONS;
    localparam int AD = (NE > 1) ? $clog2(NE) : 1;
    localparam int CI = $clog2(SECTIONS * 5);
    localparam int IW = DW + OB;
    localparam int AW = IW + CW + 3;
    localparam logic signed [AW-1:0] YMAX = {{(CW + 4){1'b0}}, {(IW - 1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = ~YMAX;
    localparam logic signed [IW-1:0] OMAX = {{(OB + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [IW-1:0] OMIN = ~OMAX;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAC, S_WB, S_OUT} state_t;

    state_t                  r_state, w_next;
    logic [AD-1:0]           r_addr;
    logic [SW-1:0]           r_sec;
    logic [2:0]              r_k;
    logic [CI-1:0]           r_ci;
    logic [CHW-1:0]          r_ch, r_ch_o;
    logic signed [IW-1:0]    r_x;
    logic signed [AW-1:0]    r_acc;
    logic [4*IW-1:0]         r_rd;
    logic signed [DW-1:0]    r_data;
    (* ramstyle = RAMSTYLE *) logic [4*IW-1:0] r_mem [NE];

    logic                    w_idle, w_accept, w_chok, w_last, w_we, w_re;
    logic [AD-1:0]           w_base, w_raddr;
    logic signed [CW-1:0]    w_coef;
    logic signed [IW-1:0]    w_op, w_x0, w_y, w_o;
    logic signed [IW+CW-1:0] w_prod;
    logic signed [AW-1:0]    w_term, w_sum, w_sh;
    logic signed [DW-1:0]    w_out;
    logic [4*IW-1:0]         w_wdata;

    // state word layout: {y2, y1, x2, x1}; MAC step k walks x, x1, x2, y1, y2
    assign w_chok  = {1'b0, channel_i} < (CHW + 1)'(CHANNELS);
    assign w_last  = r_sec == SW'(SECTIONS - 1);
    assign w_base  = AD'(channel_i) * AD'(SECTIONS);
    assign w_raddr = w_accept ? w_base : r_addr + 1'b1;
    assign w_x0    = IW'(data_i) <<< OB;
    assign w_coef  = COEFFICIENTS[r_ci];
    assign w_op    = (r_k == 3'd0) ? r_x :
                     (r_k == 3'd1) ? r_rd[0 +: IW] :
                     (r_k == 3'd2) ? r_rd[IW +: IW] :
                     (r_k == 3'd3) ? r_rd[2*IW +: IW] : r_rd[3*IW +: IW];
    assign w_prod  = w_coef * w_op;
    assign w_term  = (r_k > 3'd2) ? -AW'(w_prod) : AW'(w_prod);
    assign w_sum   = ((r_k == 3'd0) ? '0 : r_acc) + w_term;
    assign w_sh    = r_acc >>> (CW - 2);
    assign w_y     = (w_sh > YMAX) ? YMAX[IW-1:0] : (w_sh < YMIN) ? YMIN[IW-1:0] : w_sh[IW-1:0];
    assign w_o     = w_y >>> OB;
    assign w_out   = (w_o > OMAX) ? OMAX[DW-1:0] : (w_o < OMIN) ? OMIN[DW-1:0] : w_o[DW-1:0];
    assign w_we    = !srst_i && (r_state == S_CLEAR || r_state == S_WB);
    assign w_re    = w_accept || (!srst_i && r_state == S_WB && !w_last);
    assign w_wdata = (r_state == S_CLEAR) ? '0 : {r_rd[2*IW +: IW], w_y, r_rd[0 +: IW], r_x};
    assign data_o    = r_data;
    assign channel_o = r_ch_o;

    // next-state decode plus status outputs; a start is taken only in IDLE or the result cycle
    always_comb begin
        w_next       = r_state;
        w_idle       = r_state == S_IDLE || r_state == S_OUT;
        w_accept     = !srst_i && start_i && w_idle && w_chok;
        case (r_state)
            S_CLEAR:       if (r_addr == AD'(NE - 1)) w_next = S_IDLE;
            S_IDLE, S_OUT: w_next = w_accept ? S_MAC : S_IDLE;
            S_MAC:         if (r_k == 3'd4) w_next = S_WB;
            S_WB:          w_next = w_last ? S_OUT : S_MAC;
            default:       w_next = S_CLEAR;
        endcase
        busy_o       = srst_i || !w_idle;
        data_valid_o = !srst_i && r_state == S_OUT;
        drop_o       = !srst_i && start_i && !w_accept;
    end

    // state register; reset always lands in CLEAR so history is wiped
    always_ff @(posedge clk_i) begin
        if (srst_i) r_state <= S_CLEAR;
        else        r_state <= w_next;
    end

    // datapath: clear walk, sample latch, MAC accumulate, section write-back and result capture
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_addr <= '0;
            r_sec  <= '0;
            r_k    <= '0;
            r_ci   <= '0;
            r_ch   <= '0;
            r_x    <= '0;
            r_acc  <= '0;
            r_data <= '0;
            r_ch_o <= '0;
        end else if (w_accept) begin
            r_addr <= w_base;
            r_sec  <= '0;
            r_k    <= '0;
            r_ci   <= '0;
            r_ch   <= channel_i;
            r_x    <= w_x0;
        end else if (r_state == S_CLEAR) begin
            r_addr <= r_addr + 1'b1;
        end else if (r_state == S_MAC) begin
            r_acc  <= w_sum;
            r_k    <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
            r_ci   <= r_ci + 1'b1;
        end else if (r_state == S_WB) begin
            r_x    <= w_y;
            r_addr <= r_addr + 1'b1;
            r_sec  <= r_sec + 1'b1;
            if (w_last) begin
                r_data <= w_out;
                r_ch_o <= r_ch;
            end
        end
    end

    // state memory with registered read; the next section is fetched during write-back
    always_ff @(posedge clk_i) begin
        if (w_we) r_mem[r_addr] <= w_wdata;
        if (w_re) r_rd <= r_mem[w_raddr];
    end
endmodule

// File: tb/tb_mc_sos_iir.sv
// tb_mc_sos_iir: directed and random stimulus against an arithmetic reference of the biquad cascade
module tb_mc_sos_iir;
    localparam int CH = 3;
    localparam int S  = 2;
    localparam int L  = 6 * S + 1;
    localparam int N  = CH * S;
    localparam logic [S*5-1:0][15:0] COEF = {16'h1000, 16'h0000, 16'hD000, 16'h1000, 16'h6000,
                                            16'h0000, 16'hE000, 16'h0000, 16'h0000, 16'h4000};

    logic               clk = 1'b0;
    logic               srst_i = 1'b1;
    logic               start_i = 1'b0;
    logic [1:0]         channel_i = '0;
    logic signed [15:0] data_i = '0;
    logic signed [15:0] data_o;
    logic [1:0]         channel_o;
    logic               data_valid_o, busy_o, drop_o;

    int     cf [S][5] = '{'{16384, 0, 0, -8192, 0}, '{24576, 4096, -12288, 0, 4096}};
    longint mx1 [CH][S], mx2 [CH][S], my1 [CH][S], my2 [CH][S];
    bit     ev [int], eb [int], edr [int];
    int     ed [int], ec [int];
    int     cyc = 0, free_at = 0, last_d = 0, last_c = 0, vecs = 0, errs = 0;
    bit     chk_en = 1'b0;

    mc_sos_iir #(.CHANNELS(CH), .SECTIONS(S), .DW(16), .CW(16), .OB(0), .COEFFICIENTS(COEF)) dut (
        .clk_i(clk), .srst_i(srst_i), .start_i(start_i), .channel_i(channel_i), .data_i(data_i),
        .data_o(data_o), .channel_o(channel_o), .data_valid_o(data_valid_o), .busy_o(busy_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint v);
        return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
    endfunction

    function automatic int model(input int ch, input int x);
        longint v = x;
        for (int s = 0; s < S; s++) begin
            longint y = sat((cf[s][0] * v + cf[s][1] * mx1[ch][s] + cf[s][2] * mx2[ch][s]
                             - cf[s][3] * my1[ch][s] - cf[s][4] * my2[ch][s]) >>> 14);
            mx2[ch][s] = mx1[ch][s];
            mx1[ch][s] = v;
            my2[ch][s] = my1[ch][s];
            my1[ch][s] = y;
            v = y;
        end
        return int'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        while (cyc < free_at) tick();
    endtask

    task automatic rst(input int h);
        int r = cyc;
        srst_i = 1'b1;
        ev.delete();
        ed.delete();
        ec.delete();
        eb.delete();
        for (int k = r; k < r + h + N; k++) eb[k] = 1'b1;
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < S; s++) begin
                mx1[c][s] = 0;
                mx2[c][s] = 0;
                my1[c][s] = 0;
                my2[c][s] = 0;
            end
        tick();
        last_d = 0;
        last_c = 0;
        repeat (h - 1) tick();
        srst_i = 1'b0;
        free_at = r + h + N;
    endtask

    task automatic send(input int ch, input int x, output int pred);
        start_i = 1'b1;
        channel_i = 2'(ch);
        data_i = 16'(x);
        pred = 0;
        if (ch < CH && cyc >= free_at) begin
            pred = model(ch, x);
            ev[cyc + L] = 1'b1;
            ed[cyc + L] = pred;
            ec[cyc + L] = ch;
            for (int k = 1; k < L; k++) eb[cyc + k] = 1'b1;
            free_at = cyc + L;
        end else begin
            edr[cyc] = 1'b1;
        end
        tick();
        start_i = 1'b0;
    endtask

    // every cycle: status pulses, busy window, and held result/channel against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, data_valid_o}, ev.exists(cyc));
            chk("drop", {31'd0, drop_o}, edr.exists(cyc));
            chk("busy", {31'd0, busy_o}, eb.exists(cyc));
            if (ev.exists(cyc)) begin
                last_d = ed[cyc];
                last_c = ec[cyc];
            end
            chk("data", 32'(data_o), last_d);
            chk("chan", 32'(channel_o), last_c);
        end
    end

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
    end

    initial begin
        int p;
        rst(3);
        tick();
        send(0, 5, p);
        wait_free();
        send(0, 1000, p);
        chk("pin_first", p, 1500);
        tick();
        tick();
        send(1, 7, p);
        wait_free();
        send(0, 0, p);
        chk("pin_second", p, 1000);
        wait_free();
        send(1, 0, p);
        chk("pin_isolation", p, 0);
        wait_free();
        send(0, 0, p);
        chk("pin_third", p, -625);
        wait_free();
        send(3, 100, p);
        send(2, 32767, p);
        chk("pin_sat_pos", p, 32767);
        wait_free();
        send(2, -32768, p);
        chk("pin_floor", p, -16386);
        wait_free();
        send(1, 500, p);
        tick();
        tick();
        tick();
        rst(1);
        tick();
        tick();
        rst(1);
        wait_free();
        send(2, -32768, p);
        chk("pin_sat_neg", p, -32768);
        wait_free();
        send(0, 1000, p);
        chk("pin_after_reset", p, 1500);
        repeat (400) begin
            repeat ($urandom_range(16)) tick();
            send(int'($urandom_range(3)), int'($urandom_range(65535)) - 32768, p);
        end
        repeat (L + 5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
